// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment encode/decode blocks: active-low glyphs,
// segment bit order and the frame-capture state encoding.
package seg7_pkg;

  // Segment order inside a 7-bit led word: a is bit 6, g is bit 0.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_bits_t;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } cap_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-segment decoder: active-low glyph to nibble,
// flagging any pattern that is not one of the sixteen hex glyphs.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] led,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (led)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_capture.sv
// Reads back a multiplexed 4-digit common-anode display bus and rebuilds the
// 16-bit value shown, ignoring multiplex ghosting and timing out partial frames.
module seg7_frame_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  led,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  digit_err,
  output logic        stale
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0] STABLE_MAX  = SC_W'(STABLE_CYCLES);
  localparam logic [SC_W-1:0] STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
  // The counter only needs to reach TIMEOUT_CYCLES-1: expiry fires on the edge
  // that would take it to TIMEOUT_CYCLES, so a power-of-two timeout fits CNT_W.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]       an_m_q, an_s_q;
  logic [6:0]       led_m_q, led_s_q;
  cap_state_e       state_q, state_d;
  logic [3:0]       ref_an_q, ref_an_d;
  logic [6:0]       ref_led_q, ref_led_d;
  logic [SC_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [15:0]      slot_val_q, slot_val_d;
  logic [3:0]       slot_err_q, slot_err_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       digit_err_q, digit_err_d;
  logic             valid_q, valid_d;
  logic             stale_q, stale_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [3:0] an_low;
  logic       one_low;
  logic       pair_same;
  logic       capture;
  logic [1:0] cap_idx;
  logic [3:0] dec_nib;
  logic       dec_err;

  seg7_to_hex u_dec (
    .led    (ref_led_q),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  assign an_low    = ~an_s_q;
  assign one_low   = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
  assign pair_same = ({an_s_q, led_s_q} == {ref_an_q, ref_led_q});
  assign cap_idx   = onehot_to_idx(~ref_an_q);

  always_comb begin
    state_d      = state_q;
    ref_an_d     = ref_an_q;
    ref_led_d    = ref_led_q;
    stable_cnt_d = stable_cnt_q;
    mask_d       = mask_q;
    slot_val_d   = slot_val_q;
    slot_err_d   = slot_err_q;
    value_d      = value_q;
    digit_err_d  = digit_err_q;
    valid_d      = 1'b0;
    stale_d      = stale_q;
    tmo_cnt_d    = tmo_cnt_q;
    capture      = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (one_low) begin
          ref_an_d     = an_s_q;
          ref_led_d    = led_s_q;
          stable_cnt_d = SC_W'(1);
          state_d      = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!pair_same) begin
          state_d = ST_WAIT;
        end else begin
          if (stable_cnt_q != STABLE_MAX) stable_cnt_d = stable_cnt_q + SC_W'(1);
          if (stable_cnt_q == STABLE_LAST) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!pair_same) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    // A capture always restarts the timeout, even on the cycle it would expire.
    if (capture) begin
      slot_val_d[{cap_idx, 2'b00} +: 4] = dec_nib;
      slot_err_d[cap_idx]               = dec_err;
      mask_d[cap_idx]                   = 1'b1;
      tmo_cnt_d                         = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      stale_d = 1'b1;
      mask_d  = 4'h0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end

    if (mask_q == 4'hF) begin
      value_d     = slot_val_q;
      digit_err_d = slot_err_q;
      valid_d     = 1'b1;
      stale_d     = 1'b0;
      mask_d      = 4'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_m_q       <= 4'hF;
      an_s_q       <= 4'hF;
      led_m_q      <= 7'h7F;
      led_s_q      <= 7'h7F;
      state_q      <= ST_WAIT;
      ref_an_q     <= 4'hF;
      ref_led_q    <= 7'h7F;
      stable_cnt_q <= '0;
      mask_q       <= 4'h0;
      slot_val_q   <= 16'h0000;
      slot_err_q   <= 4'h0;
      value_q      <= 16'h0000;
      digit_err_q  <= 4'h0;
      valid_q      <= 1'b0;
      stale_q      <= 1'b1;
      tmo_cnt_q    <= '0;
    end else begin
      an_m_q       <= an;
      an_s_q       <= an_m_q;
      led_m_q      <= led;
      led_s_q      <= led_m_q;
      state_q      <= state_d;
      ref_an_q     <= ref_an_d;
      ref_led_q    <= ref_led_d;
      stable_cnt_q <= stable_cnt_d;
      mask_q       <= mask_d;
      slot_val_q   <= slot_val_d;
      slot_err_q   <= slot_err_d;
      value_q      <= value_d;
      digit_err_q  <= digit_err_d;
      valid_q      <= valid_d;
      stale_q      <= stale_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign digit_err = digit_err_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Self-checking bench for seg7_frame_capture: directed scenarios plus randomized
// frames checked against a glyph-table reference model.
module tb_seg7_frame_capture;

  localparam int STABLE = 4;
  localparam int TMO    = 64;
  localparam int CW     = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  led;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  digit_err;
  logic        stale;

  int checks    = 0;
  int errors    = 0;
  int valid_cnt = 0;

  logic [6:0] glyph [16];

  seg7_frame_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .an        (an),
    .led       (led),
    .value     (value),
    .valid     (valid),
    .digit_err (digit_err),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  // Count valid pulses mid-way through the high phase, clear of both edges.
  always @(posedge clk) begin
    #2;
    if (reset && valid) valid_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] a, input logic [6:0] l, input int cycles);
    an  = a;
    led = l;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    apply_stimulus(4'hF, 7'h7F, cycles);
  endtask

  // One digit window followed by a short blank gap.
  task automatic show_digit(input int idx, input logic [6:0] l, input int cycles);
    logic [3:0] a;
    a = ~(4'b0001 << idx);
    apply_stimulus(a, l, cycles);
    idle(2);
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] l);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++) if (glyph[i] == l) r = 5'(i);
    return r;
  endfunction

  function automatic logic [6:0] rand_led();
    if ($urandom_range(7) == 0) return 7'($urandom);
    return glyph[$urandom_range(15)];
  endfunction

  initial begin
    int base;
    int last;
    int d;
    int others [3];
    int k;
    logic [4:0]  dec;
    logic [15:0] exp_val;
    logic [3:0]  exp_err;
    logic [6:0]  l;

    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    reset = 1'b0;
    an    = 4'hF;
    led   = 7'h7F;
    repeat (3) @(negedge clk);
    check_output("rst_value", value, 16'h0000);
    check_output("rst_valid", valid, 1'b0);
    check_output("rst_err", digit_err, 4'h0);
    check_output("rst_stale", stale, 1'b1);
    reset = 1'b1;
    idle(3);

    $display("[TB] frame 1A2F");
    base = valid_cnt;
    show_digit(0, glyph[4'hF], 10);
    show_digit(1, glyph[4'h2], 10);
    show_digit(2, glyph[4'hA], 10);
    show_digit(3, glyph[4'h1], 10);
    idle(4);
    check_output("f1_pulses", valid_cnt - base, 1);
    check_output("f1_value", value, 16'h1A2F);
    check_output("f1_err", digit_err, 4'h0);
    check_output("f1_stale", stale, 1'b0);

    $display("[TB] short window");
    base = valid_cnt;
    show_digit(1, glyph[4'hE], 10);
    show_digit(2, glyph[4'h7], 10);
    show_digit(3, glyph[4'hC], 10);
    show_digit(0, glyph[4'h1], 3);
    idle(4);
    check_output("short_no_valid", valid_cnt - base, 0);
    show_digit(0, glyph[4'h1], 4);
    idle(4);
    check_output("short_pulses", valid_cnt - base, 1);
    check_output("short_value", value, 16'hC7E1);

    $display("[TB] illegal glyph");
    base = valid_cnt;
    show_digit(0, glyph[4'h5], 8);
    show_digit(1, 7'b1111111, 8);
    show_digit(2, glyph[4'h4], 8);
    show_digit(3, glyph[4'h3], 8);
    idle(4);
    check_output("ill_pulses", valid_cnt - base, 1);
    check_output("ill_value", value, 16'h3405);
    check_output("ill_err", digit_err, 4'b0010);

    $display("[TB] double-low anodes");
    base = valid_cnt;
    show_digit(0, glyph[4'h9], 8);
    show_digit(1, glyph[4'h8], 8);
    apply_stimulus(4'b1100, glyph[4'h6], 40);
    idle(2);
    check_output("dbl_no_valid", valid_cnt - base, 0);
    show_digit(2, glyph[4'hB], 8);
    show_digit(3, glyph[4'hD], 8);
    idle(4);
    check_output("dbl_pulses", valid_cnt - base, 1);
    check_output("dbl_value", value, 16'hDB89);
    check_output("dbl_err", digit_err, 4'h0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      base    = valid_cnt;
      last    = $urandom_range(3);
      exp_val = 16'h0000;
      exp_err = 4'h0;
      k = 0;
      for (int i = 0; i < 4; i++) if (i != last) begin others[k] = i; k++; end
      for (int s = 0; s < 6; s++) begin
        if ($urandom_range(2) == 0) show_digit($urandom_range(3), rand_led(), $urandom_range(1, 3));
        if (s < 2)      d = others[$urandom_range(2)];
        else if (s < 5) d = others[s - 2];
        else            d = last;
        if (s == 5) check_output("rnd_early", valid_cnt - base, 0);
        l   = rand_led();
        dec = ref_decode(l);
        exp_val[4*d +: 4] = dec[3:0];
        exp_err[d]        = dec[4];
        show_digit(d, l, $urandom_range(STABLE, STABLE + 4));
      end
      idle(4);
      check_output("rnd_pulses", valid_cnt - base, 1);
      check_output("rnd_value", value, exp_val);
      check_output("rnd_err", digit_err, exp_err);
      check_output("rnd_stale", stale, 1'b0);
    end

    $display("[TB] timeout");
    exp_val = value;
    exp_err = digit_err;
    base    = valid_cnt;
    show_digit(0, glyph[4'h2], 10);
    show_digit(1, glyph[4'h6], 10);
    idle(56);
    check_output("tmo_not_yet", stale, 1'b0);
    idle(4);
    check_output("tmo_stale", stale, 1'b1);
    check_output("tmo_value_hold", value, exp_val);
    check_output("tmo_err_hold", digit_err, exp_err);
    idle(10);
    show_digit(2, glyph[4'h0], 8);
    show_digit(3, glyph[4'hF], 8);
    idle(4);
    check_output("tmo_mask_cleared", valid_cnt - base, 0);
    show_digit(0, glyph[4'h3], 8);
    show_digit(1, glyph[4'hA], 8);
    idle(4);
    check_output("tmo_pulses", valid_cnt - base, 1);
    check_output("tmo_value", value, 16'hF0A3);
    check_output("tmo_stale_clear", stale, 1'b0);

    $display("[TB] reset mid-frame");
    base = valid_cnt;
    show_digit(0, glyph[4'h7], 8);
    show_digit(1, glyph[4'h7], 8);
    show_digit(2, glyph[4'h7], 8);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(2);
    show_digit(3, glyph[4'h7], 8);
    idle(4);
    check_output("rst_mid_pulses", valid_cnt - base, 0);
    check_output("rst_mid_value", value, 16'h0000);
    check_output("rst_mid_err", digit_err, 4'h0);
    check_output("rst_mid_stale", stale, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
